// File: rtl/hsv_code_pkg.sv
// Shared widths, sector encoding and small arithmetic helpers for the
// quantized-HSV to RGB decode path.
package hsv_code_pkg;

    localparam int H_BITS = 3;
    localparam int S_BITS = 2;
    localparam int V_BITS = 2;
    localparam int CODE_W = H_BITS + S_BITS + V_BITS;
    localparam int RGB_W  = 24;
    localparam int CH_W   = 8;
    localparam int H6_W   = 11;

    typedef logic [CH_W-1:0] chan_t;
    typedef logic [2:0]      sector_t;

    localparam sector_t SECT_0 = 3'd0;
    localparam sector_t SECT_1 = 3'd1;
    localparam sector_t SECT_2 = 3'd2;
    localparam sector_t SECT_3 = 3'd3;
    localparam sector_t SECT_4 = 3'd4;
    localparam sector_t SECT_5 = 3'd5;

    // Hue keeps 3 bits; the midpoint of the dropped range is 1 followed by 0s.
    function automatic chan_t expand_h(input logic [H_BITS-1:0] h, input bit mid);
        return {h, mid, 4'b0000};
    endfunction

    // Saturation and value keep 2 bits each.
    function automatic chan_t expand_sv(input logic [S_BITS-1:0] x, input bit mid);
        return {x, mid, 5'b00000};
    endfunction

    // 8x8 unsigned product, truncated back to 8 bits (>>8, no rounding).
    function automatic chan_t scale(input chan_t a, input chan_t b);
        logic [2*CH_W-1:0] prod;
        prod = (2*CH_W)'(a) * (2*CH_W)'(b);
        return prod[2*CH_W-1:CH_W];
    endfunction

endpackage

// File: rtl/hsv_sector_mix.sv
// Routes V/p/q/t onto the R, G and B channels according to the hue sector.
module hsv_sector_mix
    import hsv_code_pkg::*;
(
    input  chan_t             v_i,
    input  chan_t             p_i,
    input  chan_t             q_i,
    input  chan_t             t_i,
    input  sector_t           sector_i,
    output logic [RGB_W-1:0]  rgb_o
);

    // Per-sector channel assignment; sectors 6 and 7 cannot occur and map to grey.
    always_comb begin
        // NOTE: default assigned first so every path drives rgb_o and no latch is inferred.
        rgb_o = {v_i, v_i, v_i};
        case (sector_i)
            SECT_0:  rgb_o = {v_i, t_i, p_i};
            SECT_1:  rgb_o = {q_i, v_i, p_i};
            SECT_2:  rgb_o = {p_i, v_i, t_i};
            SECT_3:  rgb_o = {p_i, q_i, v_i};
            SECT_4:  rgb_o = {t_i, p_i, v_i};
            SECT_5:  rgb_o = {v_i, p_i, q_i};
            default: rgb_o = {v_i, v_i, v_i};
        endcase
    end

endmodule

// File: rtl/hsv_code_decoder.sv
// Re-expands 7-bit quantized HSV codes and converts them to 24-bit RGB in a
// three-stage pipeline with valid/ready flow control on both sides. The
// whole pipeline advances together whenever the output slot is free or
// being drained, so there are no internal bubbles collapsed and nothing lost.
module hsv_code_decoder
    import hsv_code_pkg::*;
#(
    parameter bit MIDPOINT_FILL = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_sof,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [RGB_W-1:0]  out_rgb,
    output logic              out_sof,
    output logic              out_valid,
    input  logic              out_ready
);

    logic en;

    // Stage 1: expanded S/V and h6 = H*6 (sector in the top 3 bits, fraction below).
    logic            s1_valid_q, s1_sof_q;
    chan_t           s1_s_q, s1_v_q;
    logic [H6_W-1:0] s1_h6_q;
    chan_t           s1_s_d, s1_v_d, h_exp;
    logic [H6_W-1:0] s1_h6_d;

    // Stage 2: V, sector and the three first-level products.
    logic            s2_valid_q, s2_sof_q;
    chan_t           s2_v_q, s2_p_q, s2_sf_q, s2_sg_q;
    sector_t         s2_sector_q;
    chan_t           s2_p_d, s2_sf_d, s2_sg_d, f_frac;
    sector_t         s2_sector_d;

    // Stage 3: final RGB.
    logic            s3_valid_q, s3_sof_q;
    logic [RGB_W-1:0] s3_rgb_q;
    logic [RGB_W-1:0] s3_rgb_d;
    chan_t           q_d, t_d;

    assign en       = !s3_valid_q || out_ready;
    assign in_ready = en;

    // Stage 1 next state: fill the dropped low bits and pre-multiply the hue.
    always_comb begin
        h_exp   = expand_h(in_code[CODE_W-1 -: H_BITS], MIDPOINT_FILL);
        s1_s_d  = expand_sv(in_code[V_BITS +: S_BITS], MIDPOINT_FILL);
        s1_v_d  = expand_sv(in_code[0 +: V_BITS], MIDPOINT_FILL);
        s1_h6_d = H6_W'(h_exp) * H6_W'(6);
    end

    // Stage 1 register: captures a new code (or a bubble) whenever the pipe advances.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: datapath registers are reset as well so out_rgb reads 0 out of reset.
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_s_q     <= '0;
            s1_v_q     <= '0;
            s1_h6_q    <= '0;
        end else if (en) begin
            // NOTE: non-blocking assignments so every stage samples the pre-edge values.
            s1_valid_q <= in_valid;
            s1_sof_q   <= in_sof && in_valid;
            s1_s_q     <= s1_s_d;
            s1_v_q     <= s1_v_d;
            s1_h6_q    <= s1_h6_d;
        end
    end

    // Stage 2 next state: split h6 into sector/fraction and form p, S*f, S*(1-f).
    always_comb begin
        s2_sector_d = s1_h6_q[H6_W-1 -: 3];
        f_frac      = s1_h6_q[CH_W-1:0];
        s2_p_d      = scale(s1_v_q, 8'd255 - s1_s_q);
        s2_sf_d     = scale(s1_s_q, f_frac);
        s2_sg_d     = scale(s1_s_q, 8'd255 - f_frac);
    end

    // Stage 2 register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid_q  <= 1'b0;
            s2_sof_q    <= 1'b0;
            s2_v_q      <= '0;
            s2_p_q      <= '0;
            s2_sf_q     <= '0;
            s2_sg_q     <= '0;
            s2_sector_q <= SECT_0;
        end else if (en) begin
            s2_valid_q  <= s1_valid_q;
            s2_sof_q    <= s1_sof_q;
            s2_v_q      <= s1_v_q;
            s2_p_q      <= s2_p_d;
            s2_sf_q     <= s2_sf_d;
            s2_sg_q     <= s2_sg_d;
            s2_sector_q <= s2_sector_d;
        end
    end

    // Stage 3 next state: falling (q) and rising (t) ramps of the sector.
    always_comb begin
        q_d = scale(s2_v_q, 8'd255 - s2_sf_q);
        t_d = scale(s2_v_q, 8'd255 - s2_sg_q);
    end

    hsv_sector_mix u_mix (
        .v_i      (s2_v_q),
        .p_i      (s2_p_q),
        .q_i      (q_d),
        .t_i      (t_d),
        .sector_i (s2_sector_q),
        .rgb_o    (s3_rgb_d)
    );

    // Stage 3 register: output slot, held while downstream stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s3_valid_q <= 1'b0;
            s3_sof_q   <= 1'b0;
            s3_rgb_q   <= '0;
        end else if (en) begin
            s3_valid_q <= s2_valid_q;
            s3_sof_q   <= s2_sof_q;
            s3_rgb_q   <= s3_rgb_d;
        end
    end

    assign out_valid = s3_valid_q;
    assign out_sof   = s3_sof_q;
    assign out_rgb   = s3_rgb_q;

endmodule

// File: tb/tb_hsv_code_decoder.sv
// Bench for hsv_code_decoder: two instances (midpoint fill and zero fill)
// share one stimulus stream; a negedge monitor compares both against an
// arithmetic HSV->RGB model through an in-order expectation queue.
module tb_hsv_code_decoder;

    typedef struct packed {
        logic [6:0] code;
        logic       sof;
    } pix_t;

    typedef struct packed {
        logic [6:0]  code;
        logic        fill;
        logic [23:0] rgb;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  in_code;
    logic        in_sof;
    logic        in_valid;
    logic        out_ready;
    logic        rdy_m, rdy_z;
    logic [23:0] rgb_m, rgb_z;
    logic        sof_m, sof_z;
    logic        ov_m, ov_z;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_in    = 0;
    int   n_out   = 0;
    int   n_sof_out = 0;
    pix_t exp_q[$];
    pix_t exp_pix;
    logic        stall_prev = 1'b0;
    logic [23:0] held_m, held_z;
    logic        held_sof;
    vec_t        vecs[6];

    always #5 clk = ~clk;

    hsv_code_decoder #(.MIDPOINT_FILL(1'b1)) u_mid (
        .clk       (clk),
        .reset     (reset),
        .in_code   (in_code),
        .in_sof    (in_sof),
        .in_valid  (in_valid),
        .in_ready  (rdy_m),
        .out_rgb   (rgb_m),
        .out_sof   (sof_m),
        .out_valid (ov_m),
        .out_ready (out_ready)
    );

    hsv_code_decoder #(.MIDPOINT_FILL(1'b0)) u_zero (
        .clk       (clk),
        .reset     (reset),
        .in_code   (in_code),
        .in_sof    (in_sof),
        .in_valid  (in_valid),
        .in_ready  (rdy_z),
        .out_rgb   (rgb_z),
        .out_sof   (sof_z),
        .out_valid (ov_z),
        .out_ready (out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer HSV->RGB from the expanded code.
    function automatic logic [23:0] model_rgb(input logic [6:0] code, input bit fill);
        int h, s, v, h6, sec, f, p, sf, sg, q, t, r, g, b;
        h   = int'(code[6:4]) * 32 + (fill ? 16 : 0);
        s   = int'(code[3:2]) * 64 + (fill ? 32 : 0);
        v   = int'(code[1:0]) * 64 + (fill ? 32 : 0);
        h6  = h * 6;
        sec = h6 / 256;
        f   = h6 % 256;
        p   = (v * (255 - s)) / 256;
        sf  = (s * f) / 256;
        sg  = (s * (255 - f)) / 256;
        q   = (v * (255 - sf)) / 256;
        t   = (v * (255 - sg)) / 256;
        case (sec)
            0:       begin r = v; g = t; b = p; end
            1:       begin r = q; g = v; b = p; end
            2:       begin r = p; g = v; b = t; end
            3:       begin r = p; g = q; b = v; end
            4:       begin r = t; g = p; b = v; end
            5:       begin r = v; g = p; b = q; end
            default: begin r = v; g = v; b = v; end
        endcase
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    // Monitor: records accepted inputs, checks every delivered output and stall stability.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            stall_prev = 1'b0;
        end else begin
            check("dut_agree", 32'({ov_z, rdy_z}), 32'({ov_m, rdy_m}));
            if (stall_prev) begin
                check("stall_valid_held", 32'(ov_m), 32'd1);
                check("stall_rgb_m_held", 32'(rgb_m), 32'(held_m));
                check("stall_rgb_z_held", 32'(rgb_z), 32'(held_z));
                check("stall_sof_held", 32'(sof_m), 32'(held_sof));
            end
            if (in_valid && rdy_m) begin
                exp_q.push_back('{code: in_code, sof: in_sof});
                n_in++;
            end
            if (ov_m && out_ready) begin
                n_out++;
                if (sof_m) n_sof_out++;
                check("out_has_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_pix = exp_q.pop_front();
                    check($sformatf("model_rgb_mid code=%0d", exp_pix.code), 32'(rgb_m),
                          32'(model_rgb(exp_pix.code, 1'b1)));
                    check($sformatf("model_rgb_zero code=%0d", exp_pix.code), 32'(rgb_z),
                          32'(model_rgb(exp_pix.code, 1'b0)));
                    check("model_sof", 32'({sof_m, sof_z}), 32'({exp_pix.sof, exp_pix.sof}));
                end
            end
            stall_prev = ov_m && !out_ready;
            held_m     = rgb_m;
            held_z     = rgb_z;
            held_sof   = sof_m;
        end
    end

    // Send one pixel with out_ready high and wait (bounded) for it to come out.
    task automatic send_one(input logic [6:0] code, input logic sof,
                            output logic [23:0] got_m, output logic [23:0] got_z,
                            output logic got_sof, output int lat);
        in_code   = code;
        in_sof    = sof;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        lat      = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (ov_m) break;
        end
        got_m   = rgb_m;
        got_z   = rgb_z;
        got_sof = sof_m;
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream();
        int  idx = 0;
        int  cycles = 0;
        bit  acc;
        n_in = 0;
        n_out = 0;
        n_sof_out = 0;
        while (idx < 128 && cycles < 4000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_code   = 7'(idx);
            in_sof    = (idx == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            acc = in_valid && rdy_m;
            @(posedge clk);
            #1;
            if (acc) idx++;
            cycles++;
        end
        check("stream_all_sent", 32'(idx), 32'd128);
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        cycles    = 0;
        while (exp_q.size() != 0 && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("stream_drained", 32'(exp_q.size()), 32'd0);
        check("stream_in_count", 32'(n_in), 32'd128);
        check("stream_out_count", 32'(n_out), 32'd128);
        check("stream_sof_count", 32'(n_sof_out), 32'd1);
    endtask

    task automatic run_mid_reset();
        logic [23:0] gm, gz;
        logic        gs;
        int          lat;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_code  = 7'(20 + k);
            in_sof   = (k == 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        check("inflight_out_valid", 32'(ov_m), 32'd1);
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_valid", 32'({ov_m, ov_z}), 32'd0);
        check("async_rst_rgb_m", 32'(rgb_m), 32'd0);
        check("async_rst_rgb_z", 32'(rgb_z), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        n_out = 0;
        repeat (6) @(posedge clk);
        #1;
        check("no_ghost_outputs", 32'(n_out), 32'd0);
        send_one(7'h5A, 1'b1, gm, gz, gs, lat);
        check("post_rst_latency", 32'(lat), 32'd3);
        check("post_rst_rgb_m", 32'(gm), 32'(model_rgb(7'h5A, 1'b1)));
        check("post_rst_sof", 32'(gs), 32'd1);
    endtask

    initial begin
        logic [23:0] gm, gz;
        logic        gs;
        int          lat;

        vecs[0] = '{code: {3'd0, 2'd3, 2'd3}, fill: 1'b1, rgb: 24'hE0651B};
        vecs[1] = '{code: {3'd4, 2'd3, 2'd3}, fill: 1'b0, rgb: 24'h2FBFC0};
        vecs[2] = '{code: {3'd0, 2'd0, 2'd3}, fill: 1'b0, rgb: 24'hC0BFBF};
        vecs[3] = '{code: {3'd5, 2'd2, 2'd0}, fill: 1'b0, rgb: 24'h000000};
        vecs[4] = '{code: {3'd7, 2'd3, 2'd0}, fill: 1'b0, rgb: 24'h000000};
        vecs[5] = '{code: {3'd7, 2'd0, 2'd0}, fill: 1'b1, rgb: 24'h201B1D};

        reset     = 1'b0;
        in_valid  = 1'b1;
        in_code   = 7'h3F;
        in_sof    = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 32'({ov_m, ov_z}), 32'd0);
        check("reset_rgb_m", 32'(rgb_m), 32'd0);
        check("reset_rgb_z", 32'(rgb_z), 32'd0);
        check("reset_sof", 32'({sof_m, sof_z}), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        reset    = 1'b1;
        #1;
        check("idle_in_ready", 32'({rdy_m, rdy_z}), 32'd3);

        send_one(7'h33, 1'b1, gm, gz, gs, lat);
        check("first_latency", 32'(lat), 32'd3);
        check("first_sof", 32'(gs), 32'd1);

        for (int i = 0; i < 6; i++) begin
            send_one(vecs[i].code, 1'b0, gm, gz, gs, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
            check($sformatf("vec%0d_rgb", i), 32'(vecs[i].fill ? gm : gz), 32'(vecs[i].rgb));
        end

        run_stream();
        run_mid_reset();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
